// File: rtl/receive_frame_pkg.sv
// receive_frame_pkg: shared frame constants, parser states and byte-time helper.
// Rev 1.0
`default_nettype none

package receive_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_SUM   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // One UART byte is 10 bit times (start + 8 data + stop).
  function automatic int byte_cycles(input int freq, input int baud);
    return (10 * freq) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/receive_frame_buffer.sv
// receive_frame_buffer: DEPTH x 8 payload RAM, one write port, one registered read port.
// Rev 1.0
`default_nettype none

module receive_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data holds between reads so the output byte stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 8'd0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/receive_frame.sv
// receive_frame: hunts SYNC, parses ADDR/LEN/payload/SUM, replays checksum-clean payloads.
// Rev 1.0
`default_nettype none

module receive_frame
  import receive_frame_pkg::*;
#(
  parameter int         BAUD  = 9600,
  parameter int         FREQ  = 12000000,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT,
  parameter int         DEPTH = 16,
  parameter int         GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_stb,
  input  logic [7:0] in_dat,
  input  logic       in_err,
  output logic       in_rdy,
  output logic       out_stb,
  output logic [7:0] out_dat,
  output logic [7:0] out_adr,
  output logic       out_lst,
  input  logic       out_rdy,
  output logic       ok,
  output logic       bad
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         CW      = AW + 1;
  localparam int         LIMIT   = GAP * byte_cycles(FREQ, BAUD);
  localparam int         TW      = $clog2(LIMIT + 1);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t          state_q, state_d;
  logic [7:0]      adr_q, adr_d;
  logic [7:0]      sum_q, sum_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   wp_q, wp_d;
  logic [CW-1:0]   rp_q, rp_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            stb_q, stb_d;
  logic            lst_q, lst_d;
  logic            ok_q, ok_d;
  logic            bad_q, bad_d;

  logic            w_acc;
  logic            w_active;
  logic            w_abort;
  logic            w_we;
  logic            w_re;
  logic [7:0]      w_sum;
  logic [7:0]      w_rdata;

  assign in_rdy   = (state_q != ST_DRAIN);
  assign w_acc    = in_stb && in_rdy;
  assign w_active = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_SUM);
  assign w_sum    = sum_q + in_dat;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sum_d   = sum_q;
    len_d   = len_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    timer_d = timer_q;
    stb_d   = stb_q;
    lst_d   = lst_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_abort = 1'b0;

    if (w_active) begin
      timer_d = w_acc ? '0 : timer_q + TW'(1);
    end

    unique case (state_q)
      ST_HUNT: begin
        if (w_acc && (in_dat == SYNC)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (w_acc) begin
          adr_d   = in_dat;
          sum_d   = in_dat;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_acc) begin
          if ((in_dat == 8'd0) || ({1'b0, in_dat} > DEPTH_W)) begin
            w_abort = 1'b1;
          end else begin
            len_d   = CW'(in_dat);
            sum_d   = w_sum;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_acc) begin
          w_we  = 1'b1;
          wp_d  = wp_q + CW'(1);
          sum_d = w_sum;
          if (wp_q == len_q - CW'(1)) state_d = ST_SUM;
        end
      end
      ST_SUM: begin
        if (w_acc) begin
          if (w_sum == 8'd0) begin
            ok_d    = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Fetch the next byte whenever the output slot is empty or being consumed.
        w_re = (rp_q != len_q) && (!stb_q || out_rdy);
        if (w_re) begin
          rp_d  = rp_q + CW'(1);
          stb_d = 1'b1;
          lst_d = (rp_q == len_q - CW'(1));
        end else if (stb_q && out_rdy) begin
          stb_d = 1'b0;
          lst_d = 1'b0;
          if (lst_q) begin
            state_d = ST_HUNT;
            wp_d    = '0;
            rp_d    = '0;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (w_active && (in_err || (!w_acc && (timer_q == TW'(LIMIT - 1))))) begin
      w_abort = 1'b1;
    end

    if (w_abort) begin
      bad_d   = 1'b1;
      ok_d    = 1'b0;
      state_d = ST_HUNT;
      wp_d    = '0;
      timer_d = '0;
      w_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      adr_q   <= 8'd0;
      sum_q   <= 8'd0;
      len_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      timer_q <= '0;
      stb_q   <= 1'b0;
      lst_q   <= 1'b0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      timer_q <= timer_d;
      stb_q   <= stb_d;
      lst_q   <= lst_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  receive_frame_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_we),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (in_dat),
    .re_i    (w_re),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (w_rdata)
  );

  assign out_stb = stb_q;
  assign out_dat = w_rdata;
  assign out_adr = adr_q;
  assign out_lst = lst_q;
  assign ok      = ok_q;
  assign bad     = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_receive_frame.sv
// tb_receive_frame: directed frames with hand-computed checksums and expected replay.
// Rev 1.0
`default_nettype none

module tb_receive_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_stb = 1'b0;
  logic [7:0] in_dat = 8'd0;
  logic       in_err = 1'b0;
  logic       in_rdy;
  logic       out_stb;
  logic [7:0] out_dat;
  logic [7:0] out_adr;
  logic       out_lst;
  logic       out_rdy = 1'b0;
  logic       ok;
  logic       bad;

  int nvec = 0;
  int nerr = 0;
  int ok_cnt = 0;
  int bad_cnt = 0;
  int both_cnt = 0;
  logic [7:0] q_dat[$];
  logic [7:0] q_adr[$];
  logic       q_lst[$];

  always #5 clk = ~clk;

  // Byte time 100 cycles, timeout after 400 idle cycles.
  receive_frame #(
    .BAUD  (9600),
    .FREQ  (96000),
    .SYNC  (8'hA5),
    .DEPTH (16),
    .GAP   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_stb  (in_stb),
    .in_dat  (in_dat),
    .in_err  (in_err),
    .in_rdy  (in_rdy),
    .out_stb (out_stb),
    .out_dat (out_dat),
    .out_adr (out_adr),
    .out_lst (out_lst),
    .out_rdy (out_rdy),
    .ok      (ok),
    .bad     (bad)
  );

  always @(negedge clk) begin
    if (ok) ok_cnt++;
    if (bad) bad_cnt++;
    if (ok && bad) both_cnt++;
    if (out_stb && out_rdy) begin
      q_dat.push_back(out_dat);
      q_adr.push_back(out_adr);
      q_lst.push_back(out_lst);
    end
  end

  task automatic clear_mon();
    ok_cnt  = 0;
    bad_cnt = 0;
    q_dat.delete();
    q_adr.delete();
    q_lst.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_stb = 1'b1;
    in_dat = b;
    while (!in_rdy && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_rdy) begin
      nvec++;
      nerr++;
      $display("FAIL send_wait: in_rdy=%b for byte %h, required 1", in_rdy, b);
    end
    @(posedge clk);
    #1;
    in_stb = 1'b0;
  endtask

  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL rst_in_rdy: got %b want 1", in_rdy); end
    nvec++; if (out_stb !== 1'b0) begin nerr++; $display("FAIL rst_out_stb: got %b want 0", out_stb); end
    nvec++; if ({ok, bad} !== 2'b00) begin nerr++; $display("FAIL rst_ok_bad: got %b want 00", {ok, bad}); end
    nvec++; if ({out_dat, out_adr, out_lst} !== 17'd0) begin nerr++; $display("FAIL rst_data: got %h want 0", {out_dat, out_adr, out_lst}); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    clear_mon();
  endtask

  task automatic test_good();
    clear_mon();
    out_rdy = 1'b1;
    send_seq(64'hA5_03_02_10_20, 5);
    send_byte(8'hCB);
    nvec++; if (ok !== 1'b1 || bad !== 1'b0) begin nerr++; $display("FAIL good_pulse: ok=%b bad=%b want ok=1 bad=0", ok, bad); end
    nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL good_in_rdy_drain: got %b want 0", in_rdy); end
    idle(10);
    nvec++; if (ok_cnt !== 1 || bad_cnt !== 0) begin nerr++; $display("FAIL good_counts: ok=%0d bad=%0d want 1/0", ok_cnt, bad_cnt); end
    nvec++; if (q_dat.size() !== 2) begin nerr++; $display("FAIL good_len: got %0d bytes want 2", q_dat.size()); end
    else begin
      nvec++;
      if ({q_dat[0], q_dat[1], q_adr[0], q_adr[1], q_lst[0], q_lst[1]} !== {8'h10, 8'h20, 8'h03, 8'h03, 1'b0, 1'b1}) begin
        nerr++;
        $display("FAIL good_data: got %h %h adr %h %h lst %b%b want 10 20 adr 03 03 lst 01",
                 q_dat[0], q_dat[1], q_adr[0], q_adr[1], q_lst[0], q_lst[1]);
      end
    end
    nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL good_back_to_hunt: in_rdy=%b want 1", in_rdy); end
  endtask

  task automatic test_bad_sum();
    clear_mon();
    send_seq(64'hA5_03_02_10_20, 5);
    send_byte(8'hCC);
    nvec++; if (bad !== 1'b1 || ok !== 1'b0) begin nerr++; $display("FAIL badsum_pulse: ok=%b bad=%b want ok=0 bad=1", ok, bad); end
    idle(10);
    nvec++; if (bad_cnt !== 1 || q_dat.size() !== 0) begin nerr++; $display("FAIL badsum_counts: bad=%0d out=%0d want 1/0", bad_cnt, q_dat.size()); end
    clear_mon();
    send_seq(64'hA5_07_01_55_A3, 5);
    idle(10);
    nvec++; if (ok_cnt !== 1 || q_dat.size() !== 1) begin nerr++; $display("FAIL badsum_next: ok=%0d out=%0d want 1/1", ok_cnt, q_dat.size()); end
    else begin
      nvec++;
      if ({q_dat[0], q_adr[0], q_lst[0]} !== {8'h55, 8'h07, 1'b1}) begin
        nerr++; $display("FAIL badsum_next_data: got %h adr %h lst %b want 55 07 1", q_dat[0], q_adr[0], q_lst[0]);
      end
    end
  endtask

  task automatic test_len();
    int e = 0;
    clear_mon();
    send_seq(64'hA5_03_00, 3);
    nvec++; if (bad !== 1'b1) begin nerr++; $display("FAIL len0_bad: got %b want 1", bad); end
    send_seq(64'hA5_03_11, 3);
    nvec++; if (bad !== 1'b1) begin nerr++; $display("FAIL len17_bad: got %b want 1", bad); end
    idle(3);
    nvec++; if (bad_cnt !== 2 || ok_cnt !== 0) begin nerr++; $display("FAIL len_counts: bad=%0d ok=%0d want 2/0", bad_cnt, ok_cnt); end
    clear_mon();
    send_seq(64'hA5_03_10, 3);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h65);
    idle(30);
    nvec++; if (ok_cnt !== 1 || bad_cnt !== 0 || q_dat.size() !== 16) begin
      nerr++; $display("FAIL len16_counts: ok=%0d bad=%0d out=%0d want 1/0/16", ok_cnt, bad_cnt, q_dat.size());
    end else begin
      for (int i = 0; i < 16; i++)
        if (q_dat[i] !== 8'(i + 1) || q_adr[i] !== 8'h03 || q_lst[i] !== (i == 15)) e++;
      nvec++; if (e !== 0) begin nerr++; $display("FAIL len16_data: %0d bad bytes want 0", e); end
    end
  endtask

  task automatic test_err();
    clear_mon();
    send_seq(64'hA5_03, 2);
    in_err = 1'b1;
    @(posedge clk);
    #1 in_err = 1'b0;
    nvec++; if (bad !== 1'b1) begin nerr++; $display("FAIL err_bad: got %b want 1", bad); end
    in_err = 1'b1;
    idle(3);
    in_err = 1'b0;
    idle(2);
    nvec++; if (bad_cnt !== 1) begin nerr++; $display("FAIL err_hunt_ignored: bad=%0d want 1", bad_cnt); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_seq(64'hA5_03_02_10, 4);
    idle(390);
    nvec++; if (bad_cnt !== 0) begin nerr++; $display("FAIL timeout_early: bad=%0d want 0", bad_cnt); end
    idle(20);
    nvec++; if (bad_cnt !== 1) begin nerr++; $display("FAIL timeout_fire: bad=%0d want 1", bad_cnt); end
    clear_mon();
    send_seq(64'hA5_03_02_10_20_CB, 6);
    idle(10);
    nvec++; if (ok_cnt !== 1 || q_dat.size() !== 2) begin nerr++; $display("FAIL timeout_recover: ok=%0d out=%0d want 1/2", ok_cnt, q_dat.size()); end
  endtask

  task automatic test_stall();
    int guard = 0;
    int held_err = 0;
    clear_mon();
    out_rdy = 1'b1;
    send_seq(64'hA5_09_04_11_22_33_44_49, 8);
    while (q_dat.size() < 2 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    out_rdy = 1'b0;
    nvec++; if ({out_stb, out_dat, out_lst} !== {1'b1, 8'h33, 1'b0}) begin
      nerr++; $display("FAIL stall_start: stb=%b dat=%h lst=%b want 1 33 0", out_stb, out_dat, out_lst);
    end
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_stb !== 1'b1 || out_dat !== 8'h33 || out_lst !== 1'b0 || in_rdy !== 1'b0) held_err++;
    end
    nvec++; if (held_err !== 0) begin nerr++; $display("FAIL stall_hold: %0d cycles changed want 0", held_err); end
    nvec++; if (q_dat.size() !== 2) begin nerr++; $display("FAIL stall_no_xfer: got %0d want 2", q_dat.size()); end
    out_rdy = 1'b1;
    idle(10);
    nvec++; if (q_dat.size() !== 4) begin nerr++; $display("FAIL stall_len: got %0d want 4", q_dat.size()); end
    else begin
      nvec++;
      if ({q_dat[0], q_dat[1], q_dat[2], q_dat[3], q_lst[0], q_lst[1], q_lst[2], q_lst[3], q_adr[3]}
          !== {32'h11223344, 4'b0001, 8'h09}) begin
        nerr++; $display("FAIL stall_data: got %h %h %h %h lst %b%b%b%b adr %h want 11 22 33 44 lst 0001 adr 09",
                         q_dat[0], q_dat[1], q_dat[2], q_dat[3], q_lst[0], q_lst[1], q_lst[2], q_lst[3], q_adr[3]);
      end
    end
  endtask

  task automatic test_junk_reset();
    clear_mon();
    send_seq(64'h00_FF, 2);
    send_seq(64'hA5_03_02_10_20_CB, 6);
    idle(10);
    nvec++; if (bad_cnt !== 0 || ok_cnt !== 1 || q_dat.size() !== 2) begin
      nerr++; $display("FAIL junk: bad=%0d ok=%0d out=%0d want 0/1/2", bad_cnt, ok_cnt, q_dat.size());
    end
    clear_mon();
    send_seq(64'hA5_03_02_10, 4);
    nvec++; if (out_adr !== 8'h03) begin nerr++; $display("FAIL pre_rst_adr: got %h want 03", out_adr); end
    #2 rst = 1'b1;
    #1;
    nvec++; if ({out_adr, out_stb, ok, bad, in_rdy} !== {8'h00, 4'b0001}) begin
      nerr++; $display("FAIL async_rst: adr=%h stb=%b ok=%b bad=%b in_rdy=%b want 00 0 0 0 1", out_adr, out_stb, ok, bad, in_rdy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    send_seq(64'h20_CB, 2);
    idle(5);
    nvec++; if (ok_cnt !== 0 || bad_cnt !== 0 || q_dat.size() !== 0) begin
      nerr++; $display("FAIL rst_discard: ok=%0d bad=%0d out=%0d want 0/0/0", ok_cnt, bad_cnt, q_dat.size());
    end
    send_seq(64'hA5_05_01_77_83, 5);
    idle(10);
    nvec++; if (ok_cnt !== 1 || q_dat.size() !== 1) begin nerr++; $display("FAIL rst_next: ok=%0d out=%0d want 1/1", ok_cnt, q_dat.size()); end
    else begin
      nvec++;
      if ({q_dat[0], q_adr[0], q_lst[0]} !== {8'h77, 8'h05, 1'b1}) begin
        nerr++; $display("FAIL rst_next_data: got %h adr %h lst %b want 77 05 1", q_dat[0], q_adr[0], q_lst[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_sum();
    test_len();
    test_err();
    test_timeout();
    test_stall();
    test_junk_reset();
    nvec++; if (both_cnt !== 0) begin nerr++; $display("FAIL ok_bad_overlap: got %0d cycles want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
